// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, default reset PC,
// the fetch FSM state encoding and the word+PC bundle used by IF/ID.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_PC_INCREMENT = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // One fetched instruction together with its sequential successor PC.
  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer that lets fetch run one word ahead while decode
// is stalled. Only instantiated when FETCH_SKID_BUF_EN is defined.
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  fetch_word_t data_i,
  output logic        full_o,
  output fetch_word_t data_o
);

  logic        full_q;
  fetch_word_t data_q;

  // Single entry: flush beats push, push beats pop.
  // NOTE: the data entry is reset as well as the full flag, so a discarded
  // wrong-path word can never be observed after reset or redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS instruction fetch stage: PC register, instruction-memory request
// handshake, IF/ID pipeline register, stall/flush/redirect handling.
// Optional build macro FETCH_SKID_BUF_EN keeps fetching one word ahead
// during a stall through fetch_skid_buffer; the IF/ID sequence is the same.
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INCREMENT = DEFAULT_PC_INCREMENT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc_plus_4,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  stale_addr_q, stale_addr_d;
  logic         discard_q, discard_d;
  fetch_word_t  held_q, held_d;
  fetch_word_t  if_id_q, if_id_d;
  logic         if_id_valid_q, if_id_valid_d;

  logic         ack_fire;
  logic         block;
  logic [31:0]  pc_inc;
  fetch_word_t  fetched;

`ifdef FETCH_SKID_BUF_EN
  logic         skid_push, skid_pop, skid_flush, skid_full;
  fetch_word_t  skid_data;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .data_i  (fetched),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  // In HOLD the next word is still requested until the skid entry is used.
  assign imem_req = (state_q == ST_REQ) || ((state_q == ST_HOLD) && !skid_full);
`else
  assign imem_req = (state_q == ST_REQ);
`endif

  // While a wrong-path request is still outstanding its address is kept
  // on the bus so the memory sees a stable request until it acks.
  assign imem_addr = discard_q ? stale_addr_q : pc_q;
  assign ack_fire  = imem_req && imem_ack;
  // Flush also blocks delivery: a word arriving under flush is parked, not lost.
  assign block     = stall || flush;
  assign pc_inc    = pc_q + PC_INCREMENT;
  assign fetched   = '{pc_plus_4: pc_inc, instr: imem_rdata};

  // Next-state logic: redirect > flush > stall > normal fetch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    stale_addr_d  = stale_addr_q;
    held_d        = held_q;
    if_id_d       = if_id_q;
    if_id_valid_d = if_id_valid_q;
`ifdef FETCH_SKID_BUF_EN
    skid_push     = 1'b0;
    skid_pop      = 1'b0;
    skid_flush    = 1'b0;
`endif

    // Decode sees a bubble unless it is stalled or a word is delivered below.
    if (flush || !stall) begin
      if_id_d.instr = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      discard_d    = imem_req && !imem_ack;
      stale_addr_d = imem_addr;
      held_d       = '0;
      state_d      = ST_REQ;
`ifdef FETCH_SKID_BUF_EN
      skid_flush   = 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (ack_fire) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              pc_d = pc_inc;
              if (block) begin
                held_d  = fetched;
                state_d = ST_HOLD;
              end else begin
                if_id_d       = fetched;
                if_id_valid_d = 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
`ifdef FETCH_SKID_BUF_EN
          if (ack_fire) pc_d = pc_inc;
          if (!block) begin
            if_id_d       = held_q;
            if_id_valid_d = 1'b1;
            if (skid_full) begin
              held_d   = skid_data;
              skid_pop = 1'b1;
            end else if (ack_fire) begin
              held_d = fetched;
            end else begin
              state_d = ST_REQ;
            end
          end else if (ack_fire) begin
            skid_push = 1'b1;
          end
`else
          if (!block) begin
            if_id_d       = held_q;
            if_id_valid_d = 1'b1;
            state_d       = ST_REQ;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset drops any in-flight request immediately.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      stale_addr_q  <= '0;
      held_q        <= '0;
      if_id_q       <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      stale_addr_q  <= stale_addr_d;
      held_q        <= held_d;
      if_id_q       <= if_id_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_pc_plus_4   = if_id_q.pc_plus_4;
  assign if_id_instruction = if_id_q.instr;
  assign if_id_valid       = if_id_valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: sequential fetch, stall during ack,
// redirect with an outstanding request, flush under stall, PC wrap and
// asynchronous reset in the middle of a request.
module tb_instr_fetch_stage;

  localparam logic [31:0] A0    = 32'h2008_0005;
  localparam logic [31:0] A1    = 32'h1111_0001;
  localparam logic [31:0] A2    = 32'h1111_0002;
  localparam logic [31:0] A3    = 32'h1111_0003;
  localparam logic [31:0] A4    = 32'h1111_0004;
  localparam logic [31:0] A5    = 32'h1111_0020;
  localparam logic [31:0] STALE = 32'hBAD0_0008;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic [31:0] pc4, w_pc4;
  logic [31:0] instr, w_instr;
  logic        valid, w_valid;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_id_pc_plus_4   (pc4),
    .if_id_instruction (instr),
    .if_id_valid       (valid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk               (clk),
    .reset             (reset),
    .imem_req          (w_req),
    .imem_addr         (w_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_id_pc_plus_4   (w_pc4),
    .if_id_instruction (w_instr),
    .if_id_valid       (w_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0040_0000);
    check("rst_pc4",   pc4, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    tick();
    reset = 1'b1;

    // IDLE -> REQ on the first edge after release.
    tick();
    check("c0_req",    32'(imem_req), 32'd1);
    check("c0_addr",   imem_addr, 32'h0040_0000);
    check("c0_valid",  32'(valid), 32'd0);
    check("w_c0_addr", w_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = A0;

    // First word lands in IF/ID one edge after its ack.
    tick();
    check("e1_pc4",     pc4, 32'h0040_0004);
    check("e1_instr",   instr, A0);
    check("e1_valid",   32'(valid), 32'd1);
    check("e1_addr",    imem_addr, 32'h0040_0004);
    check("w_e1_addr",  w_addr, 32'h0000_0000);
    check("w_e1_pc4",   w_pc4, 32'h0000_0000);
    check("w_e1_valid", 32'(w_valid), 32'd1);
    imem_rdata = A1;

    tick();
    check("e2_pc4",   pc4, 32'h0040_0008);
    check("e2_instr", instr, A1);
    // Stall for three cycles while the ack for 0x00400008 arrives.
    stall = 1'b1; imem_rdata = A2;

    tick();
    check("e3_instr", instr, A1);
    check("e3_pc4",   pc4, 32'h0040_0008);
    check("e3_valid", 32'(valid), 32'd1);
    check("e3_req",   32'(imem_req), 32'd0);
    imem_rdata = JUNK;  // ack without request must be ignored

    tick();
    check("e4_instr", instr, A1);
    check("e4_req",   32'(imem_req), 32'd0);

    tick();
    check("e5_instr", instr, A1);
    check("e5_pc4",   pc4, 32'h0040_0008);
    stall = 1'b0; imem_ack = 1'b0;

    // Release: the held word appears exactly once.
    tick();
    check("e6_pc4",   pc4, 32'h0040_000C);
    check("e6_instr", instr, A2);
    check("e6_valid", 32'(valid), 32'd1);
    check("e6_req",   32'(imem_req), 32'd1);
    check("e6_addr",  imem_addr, 32'h0040_000C);
    imem_ack = 1'b1; imem_rdata = A3;

    tick();
    check("e7_pc4",   pc4, 32'h0040_0010);
    check("e7_instr", instr, A3);
    // Redirect + flush together while an old-path ack is returning.
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0008; flush = 1'b1; imem_rdata = A4;

    tick();
    check("e8_instr", instr, 32'h0);
    check("e8_valid", 32'(valid), 32'd0);
    check("e8_pc4",   pc4, 32'h0040_0010);
    check("e8_addr",  imem_addr, 32'h0040_0008);
    check("e8_req",   32'(imem_req), 32'd1);
    redirect_valid = 1'b0; flush = 1'b0; imem_ack = 1'b0;

    tick();
    check("e9_addr", imem_addr, 32'h0040_0008);
    // Redirect while the request to 0x00400008 is still pending.
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0020;

    tick();
    check("e10_addr_stable", imem_addr, 32'h0040_0008);
    check("e10_req",         32'(imem_req), 32'd1);
    check("e10_valid",       32'(valid), 32'd0);
    redirect_valid = 1'b0;

    tick();
    check("e11_addr_stable", imem_addr, 32'h0040_0008);
    imem_ack = 1'b1; imem_rdata = STALE;

    tick();
    check("e12_valid", 32'(valid), 32'd0);
    check("e12_instr", instr, 32'h0);
    check("e12_addr",  imem_addr, 32'h0040_0020);
    imem_rdata = A5;

    tick();
    check("e13_pc4",   pc4, 32'h0040_0024);
    check("e13_instr", instr, A5);
    check("e13_valid", 32'(valid), 32'd1);
    // Stall with no ack: everything holds.
    imem_ack = 1'b0; stall = 1'b1;

    tick();
    check("e14_instr", instr, A5);
    check("e14_valid", 32'(valid), 32'd1);
    check("e14_addr",  imem_addr, 32'h0040_0024);
    check("e14_req",   32'(imem_req), 32'd1);
    flush = 1'b1;

    // Flush wins over stall.
    tick();
    check("e15_instr", instr, 32'h0);
    check("e15_valid", 32'(valid), 32'd0);
    check("e15_pc4",   pc4, 32'h0040_0024);
    check("e15_req",   32'(imem_req), 32'd1);
    flush = 1'b0; stall = 1'b0;

    // Asynchronous reset in the middle of a request, no clock edge.
    #2 reset = 1'b0;
    #1;
    check("ar_req",    32'(imem_req), 32'd0);
    check("ar_addr",   imem_addr, 32'h0040_0000);
    check("ar_pc4",    pc4, 32'h0);
    check("ar_instr",  instr, 32'h0);
    check("ar_valid",  32'(valid), 32'd0);
    check("w_ar_req",  32'(w_req), 32'd0);
    check("w_ar_addr", w_addr, 32'hFFFF_FFFC);
    reset = 1'b1;

    tick();
    check("rr_req",  32'(imem_req), 32'd1);
    check("rr_addr", imem_addr, 32'h0040_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
